rr_decode_arbiter: RTL and testbench
====================================

RR_DECODE_ARBITER -- requirements
Module: rr_decode_arbiter

Interface
REQ-001 Parameter MAXHOLD, default 16, maximum consecutive GRANT cycles before forced release; legal range 1..255.
REQ-002 clk  input  1  system clock; all state changes occur on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 E  input  1  enable, active-low; when 1, no grant is issued or held.
REQ-005 R  input  32  request lines, active-high, bit i is requester i.
REQ-006 G  output  5  binary index of the current grantee; registered.
REQ-007 L  output  32  grant select lines, active-low one-hot (decoder-style); registered.
REQ-008 V  output  1  grant valid, active-high; registered.

Function
REQ-009 The block SHALL implement states IDLE, GRANT and GAP.
REQ-010 IDLE: if E==0 and R!=0 at a rising edge, the block SHALL select the first set R bit searching upward from ptr, wrapping modulo 32, and enter GRANT.
REQ-011 Grant latency SHALL be one cycle: after the sampling edge, G=index, L[index]=0 with all other L bits 1, and V=1.
REQ-012 IDLE with E==1 or R==0 SHALL remain IDLE with L=32'hFFFFFFFF and V=0.
REQ-013 GRANT: the 8-bit hold counter cnt SHALL start at 0 on entry and increment by 1 each cycle spent in GRANT.
REQ-014 GRANT SHALL go to GAP when R[G]==0 is sampled (voluntary release).
REQ-015 GRANT SHALL go to GAP when cnt==MAXHOLD-1 and any R bit other than R[G] is set (preemption).
REQ-016 If cnt reaches MAXHOLD-1 and no other request is pending, the grant SHALL be held, with cnt saturating at MAXHOLD-1.
REQ-017 GAP SHALL last exactly one cycle with L=32'hFFFFFFFF and V=0, load ptr=(G+1) mod 32, then go to IDLE.
REQ-018 G SHALL keep its last value during GAP and IDLE.
REQ-019 Consequence of REQ-011 and REQ-017: a release sampled at edge t SHALL drive L all high after t, and the earliest new grant SHALL appear after edge t+2.
REQ-020 Wrap-around: G==31 on release SHALL load ptr=0; a search from ptr=30 with only R[1] set SHALL grant index 1.
REQ-021 E==1 sampled in any state SHALL force IDLE at that edge with L=32'hFFFFFFFF, V=0 and cnt=0; ptr SHALL remain unchanged.
REQ-022 Simultaneous voluntary release and preemption condition SHALL be treated as a single transition to GAP.
REQ-023 At every clock edge, at most one L bit SHALL be 0; V==1 iff exactly one L bit is 0, and that bit SHALL be L[G].

Reset
REQ-024 When rst is asserted, the block SHALL immediately, without waiting for clk, set state=IDLE, ptr=0, cnt=0, G=0, V=0 and L=32'hFFFFFFFF.
REQ-025 Reset asserted during GRANT SHALL drop the grant asynchronously.
REQ-026 After rst deasserts, the first arbitration SHALL occur at the next rising edge, using ptr=0.

Verification
REQ-027 Reset, then E=0, R=32'h0000_0001 -> after one edge: G=0, L=32'hFFFF_FFFE, V=1.
REQ-028 R=32'h8000_0001 with ptr=0: first grant is 0; release 0 -> L high for one cycle, then G=31 (L=32'h7FFF_FFFF); release 31 -> next grant G=0 (wrap-around).
REQ-029 MAXHOLD=4, requester 5 holds its request, requester 9 requests -> grant 5 lasts exactly 4 cycles, one GAP cycle, one IDLE cycle, then G=9.
REQ-030 MAXHOLD=4, only requester 5 requesting -> grant holds beyond 4 cycles, V stays 1, cnt saturates at 3.
REQ-031 E raised to 1 during grant 12 -> next edge L=32'hFFFF_FFFF, V=0; E back to 0 with R[12] still set -> grant 12 again, because ptr is unchanged.
REQ-032 rst pulsed mid-grant between clock edges -> L=32'hFFFF_FFFF and V=0 before the next edge; all 32 requesters asserting continuously -> grants rotate 0,1,...,31,0 with MAXHOLD spacing.

Source files
------------

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for 32 requesters with a bounded hold time.
// Outputs are a binary grant index plus active-low one-hot select lines.
module rr_decode_arbiter #(
  parameter int MAXHOLD = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        E,
  input  logic [31:0] R,
  output logic [4:0]  G,
  output logic [31:0] L,
  output logic        V
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAXHOLD - 1);

  state_t      state;
  logic [4:0]  ptr;
  logic [7:0]  cnt;
  logic [4:0]  pick;
  logic [31:0] others;
  logic        any_req;
  logic        release_now;
  logic        preempt;

  // Search upward from ptr with wrap; the downward loop lets the nearest hit win.
  always_comb begin
    pick = ptr;
    for (int i = 31; i >= 0; i--) begin
      if (R[ptr + 5'(i)]) begin
        pick = ptr + 5'(i);
      end
    end
  end

  always_comb begin
    any_req     = |R;
    others      = R & ~(32'h1 << G);
    release_now = !R[G];
    preempt     = (cnt == HOLD_LAST) && (|others);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 5'd0;
      cnt   <= 8'd0;
      G     <= 5'd0;
      L     <= 32'hFFFF_FFFF;
      V     <= 1'b0;
    end else if (E) begin
      // Disable wins in every state and leaves the rotation pointer alone.
      state <= IDLE;
      cnt   <= 8'd0;
      L     <= 32'hFFFF_FFFF;
      V     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state <= GRANT;
            cnt   <= 8'd0;
            G     <= pick;
            L     <= ~(32'h1 << pick);
            V     <= 1'b1;
          end else begin
            L <= 32'hFFFF_FFFF;
            V <= 1'b0;
          end
        end
        GRANT: begin
          if (release_now || preempt) begin
            state <= GAP;
            cnt   <= 8'd0;
            L     <= 32'hFFFF_FFFF;
            V     <= 1'b0;
          end else if (cnt != HOLD_LAST) begin
            cnt <= cnt + 8'd1;
          end
        end
        GAP: begin
          state <= IDLE;
          ptr   <= G + 5'd1;
          L     <= 32'hFFFF_FFFF;
          V     <= 1'b0;
        end
        default: begin
          state <= IDLE;
          cnt   <= 8'd0;
          L     <= 32'hFFFF_FFFF;
          V     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Scoreboard bench for rr_decode_arbiter: directed vectors push expected
// grant results, a monitor pops one per clock and compares.
module tb_rr_decode_arbiter;

  typedef struct {
    logic       v;
    logic [4:0] g;
    int         tag;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        E;
  logic [31:0] R;
  logic [4:0]  G;
  logic [31:0] L;
  logic        V;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   step_no    = 0;

  rr_decode_arbiter #(.MAXHOLD(4)) dut (
    .clk(clk),
    .rst(rst),
    .E(E),
    .R(R),
    .G(G),
    .L(L),
    .V(V)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Drive one cycle of inputs and queue what the DUT must show after the next edge.
  task automatic apply_stimulus(input logic e, input logic [31:0] r, input logic ev, input logic [4:0] eg);
    exp_t x;
    @(negedge clk);
    #1;
    E = e;
    R = r;
    step_no++;
    x.v = ev;
    x.g = eg;
    x.tag = step_no;
    exp_q.push_back(x);
  endtask

  // Monitor: compare against the oldest expectation and check the one-hot invariant.
  initial begin
    exp_t x;
    logic [31:0] exp_l;
    int zeros;
    logic ok;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        exp_l = x.v ? ~(32'h1 << x.g) : 32'hFFFF_FFFF;
        check_output($sformatf("step%0d_V", x.tag), {31'd0, V}, {31'd0, x.v});
        check_output($sformatf("step%0d_G", x.tag), {27'd0, G}, {27'd0, x.g});
        check_output($sformatf("step%0d_L", x.tag), L, exp_l);
        zeros = 0;
        for (int i = 0; i < 32; i++) if (L[i] == 1'b0) zeros++;
        ok = V ? (zeros == 1 && L[G] == 1'b0) : (zeros == 0);
        check_output($sformatf("step%0d_onehot", x.tag), {31'd0, ok}, 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  localparam logic [31:0] R5  = 32'h0000_0020;
  localparam logic [31:0] R59 = 32'h0000_0220;
  localparam logic [31:0] R12 = 32'h0000_1000;

  initial begin
    rst = 1'b1;
    E   = 1'b1;
    R   = 32'h0;
    #12;
    check_output("reset_G", {27'd0, G}, 32'd0);
    check_output("reset_V", {31'd0, V}, 32'd0);
    check_output("reset_L", L, 32'hFFFF_FFFF);
    @(negedge clk);
    rst = 1'b0;

    // First grant, then 31 after release of 0, then wrap back to 0.
    apply_stimulus(1'b0, 32'h0000_0001, 1'b1, 5'd0);
    apply_stimulus(1'b0, 32'h8000_0001, 1'b1, 5'd0);
    apply_stimulus(1'b0, 32'h8000_0000, 1'b0, 5'd0);
    apply_stimulus(1'b0, 32'h8000_0000, 1'b0, 5'd0);
    apply_stimulus(1'b0, 32'h8000_0000, 1'b1, 5'd31);
    apply_stimulus(1'b0, 32'h0000_0001, 1'b0, 5'd31);
    apply_stimulus(1'b0, 32'h0000_0001, 1'b0, 5'd31);
    apply_stimulus(1'b0, 32'h0000_0001, 1'b1, 5'd0);
    apply_stimulus(1'b0, 32'h0, 1'b0, 5'd0);
    apply_stimulus(1'b0, 32'h0, 1'b0, 5'd0);
    apply_stimulus(1'b0, 32'h0, 1'b0, 5'd0);

    // Preemption: 5 holds 4 cycles, GAP, IDLE, then 9.
    apply_stimulus(1'b0, R59, 1'b1, 5'd5);
    repeat (3) apply_stimulus(1'b0, R59, 1'b1, 5'd5);
    apply_stimulus(1'b0, R59, 1'b0, 5'd5);
    apply_stimulus(1'b0, R59, 1'b0, 5'd5);
    apply_stimulus(1'b0, R59, 1'b1, 5'd9);
    apply_stimulus(1'b0, 32'h0, 1'b0, 5'd9);
    apply_stimulus(1'b0, 32'h0, 1'b0, 5'd9);

    // Lone requester holds past MAXHOLD; a late competitor preempts at once.
    apply_stimulus(1'b0, R5, 1'b1, 5'd5);
    repeat (6) apply_stimulus(1'b0, R5, 1'b1, 5'd5);
    apply_stimulus(1'b0, R59, 1'b0, 5'd5);
    apply_stimulus(1'b0, R59, 1'b0, 5'd5);
    apply_stimulus(1'b0, R59, 1'b1, 5'd9);
    apply_stimulus(1'b0, 32'h0, 1'b0, 5'd9);
    apply_stimulus(1'b0, 32'h0, 1'b0, 5'd9);

    // Disable mid-grant keeps ptr at 10, so 12 beats 3 on re-enable.
    apply_stimulus(1'b0, R12, 1'b1, 5'd12);
    apply_stimulus(1'b0, R12, 1'b1, 5'd12);
    apply_stimulus(1'b1, R12, 1'b0, 5'd12);
    apply_stimulus(1'b0, R12 | 32'h8, 1'b1, 5'd12);
    apply_stimulus(1'b0, 32'h0, 1'b0, 5'd12);
    apply_stimulus(1'b0, 32'h0, 1'b0, 5'd12);

    // Asynchronous reset between edges drops the grant.
    apply_stimulus(1'b0, R12, 1'b1, 5'd12);
    @(posedge clk);
    #3;
    rst = 1'b1;
    E   = 1'b1;
    R   = 32'h0;
    #1;
    check_output("async_rst_V", {31'd0, V}, 32'd0);
    check_output("async_rst_L", L, 32'hFFFF_FFFF);
    check_output("async_rst_G", {27'd0, G}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Everybody requests: rotation 0..31 then 0, six cycles per grantee.
    for (int k = 0; k <= 32; k++) begin
      repeat (4) apply_stimulus(1'b0, 32'hFFFF_FFFF, 1'b1, 5'(k % 32));
      if (k < 32) begin
        repeat (2) apply_stimulus(1'b0, 32'hFFFF_FFFF, 1'b0, 5'(k));
      end
    end

    @(negedge clk);
    E = 1'b1;
    R = 32'h0;
    repeat (2) @(negedge clk);
    check_output("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
